// File: rtl/tap_streamer_pkg.sv
// Shared defaults, state encoding and width helper for the tap streamer.
package tap_streamer_pkg;

  localparam int unsigned NTAPS_DEF = 16;
  localparam int unsigned DW_DEF    = 14;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  // Index width, kept at least one bit so a single-tap build still elaborates.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tap_streamer_if.sv
// Beat stream from the tap streamer to the downstream MAC.
interface tap_streamer_if
  import tap_streamer_pkg::*;
#(
  parameter int unsigned NTAPS = NTAPS_DEF,
  parameter int unsigned DW    = DW_DEF
);
  localparam int unsigned IW = idx_width(NTAPS);

  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [IW-1:0] out_idx;
  logic          out_last;
  logic          out_ready;

  modport master (output out_valid, out_data, out_idx, out_last, input out_ready);
  modport slave  (input out_valid, out_data, out_idx, out_last, output out_ready);

endinterface

// File: rtl/tap_streamer_snapshot_bank.sv
// NTAPS x DW capture bank: loads every tap in one cycle, read back by index.
module tap_snapshot_bank
  import tap_streamer_pkg::*;
#(
  parameter int unsigned NTAPS = NTAPS_DEF,
  parameter int unsigned DW    = DW_DEF,
  localparam int unsigned IW   = idx_width(NTAPS)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                load_en,
  input  logic [NTAPS*DW-1:0] tap_bus,
  input  logic [IW-1:0]       rd_idx,
  output logic [DW-1:0]       rd_data
);

  logic [DW-1:0] mem_q [NTAPS];
  logic [DW-1:0] mem_d [NTAPS];

  always_comb begin
    mem_d = mem_q;
    if (load_en) begin
      for (int k = 0; k < int'(NTAPS); k++) begin
        mem_d[k] = tap_bus[DW*k +: DW];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < int'(NTAPS); k++) begin
        mem_q[k] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/tap_streamer.sv
// Snapshots the delay-line taps on start and streams them out one beat per
// accepted handshake, tap 0 first.
module tap_streamer
  import tap_streamer_pkg::*;
#(
  parameter int unsigned NTAPS = NTAPS_DEF,
  parameter int unsigned DW    = DW_DEF
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic                abort,
  input  logic [NTAPS*DW-1:0] tap_bus,
  output logic                busy,
  output logic                done,
  tap_streamer_if.master      stream
);

  localparam int unsigned     IW       = idx_width(NTAPS);
  localparam logic [IW-1:0]   LAST_IDX = IW'(NTAPS - 1);

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          done_q, done_d;
  logic          load_c;
  logic          valid_c;
  logic [DW-1:0] rd_data;

  tap_snapshot_bank #(.NTAPS(NTAPS), .DW(DW)) u_bank (
    .clk     (clk),
    .rstn    (rstn),
    .load_en (load_c),
    .tap_bus (tap_bus),
    .rd_idx  (idx_q),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  // Abort wins over a same-cycle transfer; start is only looked at in IDLE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    load_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          load_c  = 1'b1;
          idx_d   = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (abort) begin
          state_d = IDLE;
          idx_d   = '0;
        end else if (stream.out_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Outputs decode only from registered state, index and snapshot contents.
  assign valid_c          = (state_q == STREAM);
  assign stream.out_valid = valid_c;
  assign stream.out_data  = valid_c ? rd_data : '0;
  assign stream.out_idx   = valid_c ? idx_q : '0;
  assign stream.out_last  = valid_c && (idx_q == LAST_IDX);
  assign busy             = valid_c;
  assign done             = done_q;

endmodule

// File: tb/tb_tap_streamer.sv
// Directed bench for tap_streamer with a queue-based reference of the frame.
module tb_tap_streamer;

  localparam int unsigned NTAPS = 16;
  localparam int unsigned DW    = 14;

  logic                clk;
  logic                rstn;
  logic                start;
  logic                abort;
  logic [NTAPS*DW-1:0] tap_bus;
  logic                busy;
  logic                done;

  tap_streamer_if #(.NTAPS(NTAPS), .DW(DW)) bus ();

  tap_streamer #(.NTAPS(NTAPS), .DW(DW)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .start   (start),
    .abort   (abort),
    .tap_bus (tap_bus),
    .busy    (busy),
    .done    (done),
    .stream  (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Reference: the frame still owed downstream is a queue of snapshot values.
  logic [DW-1:0] pend[$];
  bit            m_done;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend.delete();
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (pend.size() == 0) begin
        if (start && !abort)
          for (int k = 0; k < int'(NTAPS); k++) pend.push_back(tap_bus[DW*k +: DW]);
      end else if (abort) begin
        pend.delete();
      end else if (bus.out_ready) begin
        void'(pend.pop_front());
        if (pend.size() == 0) m_done = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    bit act;
    act = (pend.size() != 0);
    check("out_valid", bus.out_valid, act);
    check("busy",      busy,          act);
    check("done",      done,          m_done);
    check("out_data",  bus.out_data,  act ? pend[0] : 0);
    check("out_idx",   bus.out_idx,   act ? int'(NTAPS) - pend.size() : 0);
    check("out_last",  bus.out_last,  act && pend.size() == 1);
  end

  // Record what actually transferred and when done pulsed.
  int got[$];
  int got_cyc[$];
  int done_cyc[$];
  int done_cnt = 0;

  always @(negedge clk) begin
    if (rstn && bus.out_valid && bus.out_ready && !abort) begin
      got.push_back(int'(bus.out_data));
      got_cyc.push_back(cyc);
    end
    if (rstn && done) begin
      done_cnt++;
      done_cyc.push_back(cyc);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_ramp();
    for (int k = 0; k < int'(NTAPS); k++) tap_bus[DW*k +: DW] = DW'(100 + k);
  endtask

  task automatic clear_log();
    got.delete();
    got_cyc.delete();
    done_cyc.delete();
    done_cnt = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic check_ramp(input string name);
    check({name, "_beats"}, got.size(), NTAPS);
    for (int i = 0; i < got.size() && i < int'(NTAPS); i++)
      check({name, "_data"}, got[i], 100 + i);
  endtask

  task automatic wait_idx(input int target, input int maxc);
    int n = 0;
    while (!(bus.out_valid && int'(bus.out_idx) == target) && n < maxc) begin
      step(1);
      n++;
    end
    check("wait_idx_timeout", n < maxc, 1);
  endtask

  initial begin
    rstn      = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    tap_bus   = '0;
    bus.out_ready = 1'b0;
    step(2);
    check("rst_valid", bus.out_valid, 0);
    check("rst_data",  bus.out_data,  0);
    check("rst_busy",  busy,          0);
    rstn = 1'b1;
    step(1);

    // Full-rate frame from a ramp of taps.
    set_ramp();
    bus.out_ready = 1'b1;
    clear_log();
    pulse_start();
    check("lat_valid", bus.out_valid, 1);
    check("lat_idx",   bus.out_idx,   0);
    check("lat_data",  bus.out_data,  100);
    check("lat_busy",  busy,          1);
    step(20);
    check_ramp("full");
    check("full_done_cnt", done_cnt, 1);
    if (got_cyc.size() == int'(NTAPS) && done_cyc.size() == 1) begin
      check("full_no_bubble", got_cyc[NTAPS-1] - got_cyc[0], NTAPS - 1);
      check("full_done_time", done_cyc[0] - got_cyc[NTAPS-1], 1);
    end else begin
      check("full_log_size", got_cyc.size(), NTAPS);
    end

    // Back-pressured frame: ready pattern 1,0,0,1 repeating.
    clear_log();
    pulse_start();
    for (int c = 0; c < 80; c++) begin
      bus.out_ready = (c % 4 == 0) || (c % 4 == 3);
      step(1);
    end
    bus.out_ready = 1'b1;
    check_ramp("stall");
    check("stall_done_cnt", done_cnt, 1);

    // Taps scribbled during the frame must not leak into it.
    clear_log();
    pulse_start();
    for (int k = 0; k < int'(NTAPS); k++) tap_bus[DW*k +: DW] = DW'(14'h3FFF);
    step(20);
    check_ramp("isolate");
    set_ramp();

    // Abort at index 5 with ready high.
    clear_log();
    pulse_start();
    wait_idx(5, 20);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    check("abort_valid", bus.out_valid, 0);
    check("abort_busy",  busy,          0);
    check("abort_beats", got.size(),    5);
    step(3);
    check("abort_no_done", done_cnt, 0);
    pulse_start();
    check("restart_idx",  bus.out_idx,  0);
    check("restart_data", bus.out_data, 100);
    step(20);

    // start together with abort in IDLE is dropped.
    start = 1'b1;
    abort = 1'b1;
    step(1);
    start = 1'b0;
    abort = 1'b0;
    check("abort_start_idle", bus.out_valid, 0);

    // start held high: one frame every NTAPS+1 cycles.
    clear_log();
    start = 1'b1;
    step(60);
    check("hold_frames", done_cyc.size() >= 3, 1);
    if (done_cyc.size() >= 3) begin
      check("hold_period0", done_cyc[1] - done_cyc[0], NTAPS + 1);
      check("hold_period1", done_cyc[2] - done_cyc[1], NTAPS + 1);
    end
    check("hold_beats", got.size(), int'(NTAPS) * done_cyc.size() + ((got.size() % NTAPS)));
    wait_idx(8, 40);
    #2;
    rstn = 1'b0;
    #1;
    check("arst_valid", bus.out_valid, 0);
    check("arst_data",  bus.out_data,  0);
    check("arst_idx",   bus.out_idx,   0);
    check("arst_last",  bus.out_last,  0);
    check("arst_busy",  busy,          0);
    check("arst_done",  done,          0);
    start = 1'b0;
    step(2);
    done_cnt = 0;
    rstn = 1'b1;
    step(5);
    check("arst_no_done", done_cnt, 0);
    check("arst_idle",    bus.out_valid, 0);

    // First rising edge after reset release takes a start.
    rstn = 1'b0;
    step(2);
    start = 1'b1;
    rstn  = 1'b1;
    step(1);
    start = 1'b0;
    check("first_edge_valid", bus.out_valid, 1);
    check("first_edge_data",  bus.out_data,  100);
    step(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
